// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared state and direction encodings for the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/tick_edge_detect.sv
// ============================================================================
// Module      : tick_edge_detect
// Description : Rising-edge pulse from a level input; built only when
//               TICK_EDGE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef TICK_EDGE_EN
module tick_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_in_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_d <= 1'b0;
        end else begin
            r_in_d <= in;
        end
    end

    // Current sample against the delayed one keeps the latency at one cycle.
    assign pulse = in & ~r_in_d;

endmodule
`endif

`default_nettype wire

// File: rtl/tick_updown_counter.sv
// ============================================================================
// Module      : tick_updown_counter
// Description : Tick-driven up/down counter with run/pause/idle control,
//               load/clear, wrap or saturate, terminal-count pulse.
//               Define TICK_EDGE_EN to step on tick rising edges only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;
    logic             w_tick_eff;
    logic             w_step;

`ifdef TICK_EDGE_EN
    tick_edge_detect u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .in    (tick),
        .pulse (w_tick_eff)
    );
`else
    assign w_tick_eff = tick;
`endif

    assign w_step = (r_state == ST_RUN) && w_tick_eff;

    always_comb begin
        w_next_state = r_state;
        w_next_count = count;
        w_next_tc    = 1'b0;
        if (clr) begin
            w_next_count = '0;
            w_next_state = ST_IDLE;
        end else if (load) begin
            w_next_count = (load_val > C_MAX) ? C_MAX : load_val;
        end else begin
            // stop dominates a simultaneous start
            if (stop) begin
                if (r_state == ST_RUN) begin
                    w_next_state = ST_PAUSE;
                end
            end else if (start) begin
                w_next_state = ST_RUN;
            end
            if (w_step) begin
                if (dir == DIR_UP) begin
                    if (count < C_MAX) begin
                        w_next_count = count + 1'b1;
                    end else begin
                        w_next_tc = 1'b1;
                        if (WRAP != 0) begin
                            w_next_count = '0;
                        end else begin
                            w_next_state = ST_PAUSE;
                        end
                    end
                end else begin
                    if (count != '0) begin
                        w_next_count = count - 1'b1;
                    end else begin
                        w_next_tc = 1'b1;
                        if (WRAP != 0) begin
                            w_next_count = C_MAX;
                        end else begin
                            w_next_state = ST_PAUSE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            count   <= '0;
            running <= 1'b0;
            tc      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            count   <= w_next_count;
            running <= (w_next_state == ST_RUN);
            tc      <= w_next_tc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_updown_counter.sv
// ============================================================================
// Module      : tb_tick_updown_counter
// Description : Directed self-checking bench; instance A uses 255/wrap,
//               instance B uses 9/saturate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_tick = 0, a_start = 0, a_stop = 0, a_clr = 0, a_dir = 1, a_load = 0;
    logic [7:0] a_load_val = 8'd0;
    logic [7:0] a_count;
    logic       a_running, a_tc;

    logic       b_tick = 0, b_start = 0, b_stop = 0, b_clr = 0, b_dir = 1, b_load = 0;
    logic [7:0] b_load_val = 8'd0;
    logic [7:0] b_count;
    logic       b_running, b_tc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tick_updown_counter #(.WIDTH(8), .MAX_VAL(255), .WRAP(1)) dut_a (
        .clk(clk), .reset(reset), .tick(a_tick), .start(a_start), .stop(a_stop),
        .clr(a_clr), .dir(a_dir), .load(a_load), .load_val(a_load_val),
        .count(a_count), .running(a_running), .tc(a_tc)
    );

    tick_updown_counter #(.WIDTH(8), .MAX_VAL(9), .WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .tick(b_tick), .start(b_start), .stop(b_stop),
        .clr(b_clr), .dir(b_dir), .load(b_load), .load_val(b_load_val),
        .count(b_count), .running(b_running), .tc(b_tc)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_edge;
        // reset state
        #12;
        chk("rst_count", a_count, 0);
        chk("rst_running", a_running, 0);
        chk("rst_tc", a_tc, 0);
        reset = 1'b0;
        cyc();

        // start, three separated up ticks
        a_start = 1; cyc(); a_start = 0;
        chk("start_running", a_running, 1);
        chk("start_count", a_count, 0);
        for (int i = 1; i <= 3; i++) begin
            a_dir = 1; a_tick = 1; cyc(); a_tick = 0;
            chk("up_count", a_count, i);
            chk("up_tc", a_tc, 0);
            cyc();
            chk("up_hold", a_count, i);
        end
        chk("up_running", a_running, 1);

        // wrap at MAX_VAL
        a_load = 1; a_load_val = 8'd254; cyc(); a_load = 0;
        chk("load254", a_count, 254);
        a_tick = 1; cyc(); a_tick = 0;
        chk("wrap_255", a_count, 255);
        chk("wrap_tc0", a_tc, 0);
        cyc();
        a_tick = 1; cyc(); a_tick = 0;
        chk("wrap_0", a_count, 0);
        chk("wrap_tc1", a_tc, 1);
        cyc();
        chk("wrap_tc_clear", a_tc, 0);

        // down wrap from 0 to MAX_VAL
        a_dir = 0; a_tick = 1; cyc(); a_tick = 0;
        chk("dnwrap_count", a_count, 255);
        chk("dnwrap_tc", a_tc, 1);
        cyc();

        // load beats step in the same cycle
        a_dir = 1; a_load = 1; a_load_val = 8'd200; a_tick = 1; cyc();
        a_load = 0; a_tick = 0;
        chk("load_no_step", a_count, 200);
        chk("load_keeps_run", a_running, 1);

        // start+stop together: stop wins
        a_start = 1; a_stop = 1; cyc(); a_start = 0; a_stop = 0;
        chk("startstop_pause", a_running, 0);
        a_tick = 1; cyc(); a_tick = 0; cyc();
        chk("pause_ignores_tick", a_count, 200);
        a_start = 1; a_stop = 1; cyc(); a_start = 0; a_stop = 0;
        chk("pause_stays", a_running, 0);

        // clr beats load
        a_start = 1; cyc(); a_start = 0;
        chk("resume_run", a_running, 1);
        a_load = 1; a_load_val = 8'd77; cyc(); a_load = 0;
        chk("load77", a_count, 77);
        a_clr = 1; a_load = 1; a_load_val = 8'd33; cyc(); a_clr = 0; a_load = 0;
        chk("clr_count", a_count, 0);
        chk("clr_running", a_running, 0);
        a_tick = 1; cyc(); a_tick = 0; cyc();
        chk("idle_ignores_tick", a_count, 0);

        // instance B: saturate at 0, auto-pause
        b_start = 1; cyc(); b_start = 0;
        b_load = 1; b_load_val = 8'd1; cyc(); b_load = 0;
        chk("b_load1", b_count, 1);
        b_dir = 0; b_tick = 1; cyc(); b_tick = 0;
        chk("b_down0", b_count, 0);
        chk("b_down0_tc", b_tc, 0);
        cyc();
        b_tick = 1; cyc(); b_tick = 0;
        chk("b_sat_count", b_count, 0);
        chk("b_sat_tc", b_tc, 1);
        chk("b_sat_pause", b_running, 0);
        cyc();
        chk("b_sat_tc_clear", b_tc, 0);
        b_tick = 1; cyc(); b_tick = 0; cyc();
        chk("b_sat_hold", b_count, 0);
        // load clamps to MAX_VAL, then saturate upward
        b_load = 1; b_load_val = 8'd15; cyc(); b_load = 0;
        chk("b_load_clamp", b_count, 9);
        b_start = 1; cyc(); b_start = 0;
        b_dir = 1; b_tick = 1; cyc(); b_tick = 0;
        chk("b_upsat_count", b_count, 9);
        chk("b_upsat_tc", b_tc, 1);
        chk("b_upsat_pause", b_running, 0);

        // held tick: one step with edge detect, five without
`ifdef TICK_EDGE_EN
        exp_edge = 11;
`else
        exp_edge = 15;
`endif
        a_dir = 1; a_load = 1; a_load_val = 8'd10; cyc(); a_load = 0;
        a_start = 1; cyc(); a_start = 0;
        a_tick = 1;
        repeat (5) cyc();
        a_tick = 0;
        cyc();
        chk("held_tick", a_count, exp_edge);

        // asynchronous reset mid-tick
        a_tick = 1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_count", a_count, 0);
        chk("async_running", a_running, 0);
        chk("async_tc", a_tc, 0);
        chk("async_b_count", b_count, 0);
        a_tick = 0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_updown_counter.md
Name: tick_updown_counter

Overview:
- Consumer end of the divider tick interface: takes the one-cycle `tick` strobe and advances a WIDTH-bit up/down count once per tick.
- Provides a run/pause/idle control FSM, synchronous load and clear, bounded range with wrap or saturate, and a terminal-count pulse.
- Sits between `clock_divider` and the display/LED logic of the 8-bit up/down counter design.

Parameters:
- WIDTH, 8, count width in bits.
- MAX_VAL, 255, inclusive upper bound of the count range (0..MAX_VAL); must be ≤ 2^WIDTH-1.
- WRAP, 1, 1 = wrap at boundaries; 0 = saturate at the boundary and auto-pause.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  step strobe from the clock divider.
- start  input  1  pulse: enter/resume RUN.
- stop  input  1  pulse: enter PAUSE from RUN.
- clr  input  1  synchronous clear to 0 and IDLE.
- dir  input  1  1 = count up, 0 = count down; sampled on each step.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value.
- count  output  WIDTH  current count (registered).
- running  output  1  high while state = RUN.
- tc  output  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset (async, active-high) values:
  - count = 0
  - state = IDLE
  - running = 0
  - tc = 0
  - any internal tick history = 0
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start → RUN.
  - RUN: stop → PAUSE. Saturation hit (WRAP=0) → PAUSE.
  - PAUSE: start → RUN.
  - Any state: clr → IDLE.
  - start and stop in the same cycle: stop wins, so RUN → PAUSE and IDLE/PAUSE stay put.
- running is high exactly while state = RUN. It is registered and changes on the same edge as the state.
- Step qualifier: state = RUN and the effective tick are both high (see Optional Feature).
  - Count updates on the clk edge that samples the qualifier, i.e. 1-cycle latency from tick to count.
- Priority per cycle: clr > load > step.
  - clr: count = 0, tc = 0.
  - load: count = min(load_val, MAX_VAL), state unchanged, tc = 0, no step that cycle.
- Up step:
  - count < MAX_VAL → count + 1.
  - count = MAX_VAL and WRAP=1 → count = 0, tc = 1.
  - count = MAX_VAL and WRAP=0 → count holds, tc = 1, state → PAUSE.
- Down step:
  - count > 0 → count - 1.
  - count = 0 and WRAP=1 → count = MAX_VAL, tc = 1.
  - count = 0 and WRAP=0 → count holds, tc = 1, state → PAUSE.
- tc is high for exactly one cycle, coincident with the wrapped/held count. tc is 0 in every other cycle.
- dir change between ticks takes effect on the next step. No glitch on count.
- tick outside RUN is ignored, with no side effects.
- Arithmetic is unsigned, WIDTH bits. MAX_VAL comparison is done at WIDTH bits.
- Reset asserted mid-RUN returns all outputs to reset values immediately (asynchronously).

Optional Feature:
- Macro: TICK_EDGE_EN.
- Defined:
  - tick is registered, and effective tick = tick & ~tick_d (rising edge only).
  - A tick held high for N cycles produces one step.
  - Latency from tick rise to count change = 1 cycle (edge detect combines current and delayed sample).
  - tick_d resets to 0.
- Undefined:
  - effective tick = tick (level).
  - Every RUN cycle with tick high steps once.

Decomposition:
- Shared package `counter_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - Direction constants DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Reused by the display block.
- Sub-module `tick_edge_detect` (clk, reset, in, pulse): instantiated only under TICK_EDGE_EN.
- Everything else stays in one module.

Test Plan:
- Reset then start; apply 3 single-cycle ticks with dir=1 → count 1, 2, 3 (each one cycle after its tick); running=1; tc never asserts.
- Load 254 (MAX_VAL=255, WRAP=1), dir=1, two ticks → count 255 then 0; tc=1 only in the cycle count becomes 0.
- WRAP=0, MAX_VAL=9, load 1, dir=0, two ticks → count 0, then holds at 0 with tc=1; state PAUSE, running=0; further ticks leave count 0.
- In RUN, load=1 with load_val=200 and tick in the same cycle (MAX_VAL=255) → count=200, no step. Then start+stop together → PAUSE; ticks ignored.
- clr and load in the same cycle during RUN with count=77 → count=0, IDLE, running=0. Reset asserted mid-tick → all outputs 0 asynchronously.
- With TICK_EDGE_EN, tick held high 5 cycles in RUN, dir=1 from 10 → count=11 only. Without the macro, same stimulus → count=15.
